// File: rtl/arp_resolver.sv
// arp_resolver: next-hop MAC resolution for the IP transmit path.
// A small fully-associative IP->MAC cache is filled by the ARP receive path.
// On a miss, broadcast who-has queries are issued with a timed retry, and an
// error is returned once every attempt has expired. Broadcast destinations
// resolve straight to the all-ones MAC. Off-subnet destinations are resolved
// through the gateway.
module arp_resolver #(
  parameter int CACHE_ENTRIES  = 4,
  parameter int RETRY_COUNT    = 4,
  parameter int RETRY_INTERVAL = 250000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arp_request_valid,
  output logic        arp_request_ready,
  input  logic [31:0] arp_request_ip,
  output logic        arp_response_valid,
  input  logic        arp_response_ready,
  output logic        arp_response_error,
  output logic [47:0] arp_response_mac,
  input  logic        cache_update_valid,
  input  logic [31:0] cache_update_ip,
  input  logic [47:0] cache_update_mac,
  input  logic        cache_clear,
  output logic        query_valid,
  input  logic        query_ready,
  output logic [31:0] query_ip,
  input  logic [31:0] local_ip,
  input  logic [31:0] gateway_ip,
  input  logic [31:0] subnet_mask,
  output logic        busy
);

  localparam int PTR_W = (CACHE_ENTRIES > 1) ? $clog2(CACHE_ENTRIES) : 1;
  localparam int TMR_W = $clog2(RETRY_INTERVAL + 1);
  localparam int ATT_W = $clog2(RETRY_COUNT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RETRY_INTERVAL);
  localparam logic [ATT_W-1:0] ATT_LOAD = ATT_W'(RETRY_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_QUERY,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t state_q, state_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [47:0]       rsp_mac_q, rsp_mac_d;
  logic              qv_q, qv_d;
  logic [31:0]       qip_q, qip_d;
  logic              busy_q, busy_d;
  logic [31:0]       target_q, target_d;
  logic [ATT_W-1:0]  att_q, att_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  // cache storage
  logic [CACHE_ENTRIES-1:0]       cv_q, cv_d;
  logic [CACHE_ENTRIES-1:0][31:0] cip_q, cip_d;
  logic [CACHE_ENTRIES-1:0][47:0] cmac_q, cmac_d;
  logic [PTR_W-1:0]               ptr_q, ptr_d;

  logic             upd_ok;
  logic             upd_hit;
  logic [PTR_W-1:0] upd_idx;
  logic             tbl_hit;
  logic [47:0]      tbl_mac;
  logic             byp_hit;
  logic             hit;
  logic [47:0]      hit_mac;
  logic             is_bcast;
  logic             off_net;

  assign arp_request_ready  = req_ready_q;
  assign arp_response_valid = rsp_valid_q;
  assign arp_response_error = rsp_err_q;
  assign arp_response_mac   = rsp_mac_q;
  assign query_valid        = qv_q;
  assign query_ip           = qip_q;
  assign busy               = busy_q;

  // an update is dropped when it carries IP 0 or collides with a clear
  assign upd_ok = cache_update_valid && !cache_clear && (cache_update_ip != '0);

  // request classification, using config sampled at the accept cycle
  assign is_bcast = (arp_request_ip == '1) || ((arp_request_ip | subnet_mask) == '1);
  assign off_net  = ((arp_request_ip ^ local_ip) & subnet_mask) != '0;

  // find an existing valid entry for the incoming update
  always_comb begin
    upd_hit = 1'b0;
    upd_idx = '0;
    for (int i = 0; i < CACHE_ENTRIES; i++) begin
      if (cv_q[i] && (cip_q[i] == cache_update_ip)) begin
        upd_hit = 1'b1;
        upd_idx = PTR_W'(i);
      end
    end
  end

  // cache write: refresh a matching entry, otherwise round-robin replace
  always_comb begin
    cv_d   = cv_q;
    cip_d  = cip_q;
    cmac_d = cmac_q;
    ptr_d  = ptr_q;
    if (cache_clear) begin
      cv_d  = '0;
      ptr_d = '0;
    end else if (upd_ok) begin
      if (upd_hit) begin
        cmac_d[upd_idx] = cache_update_mac;
      end else begin
        cv_d[ptr_q]   = 1'b1;
        cip_d[ptr_q]  = cache_update_ip;
        cmac_d[ptr_q] = cache_update_mac;
        ptr_d         = ptr_q + PTR_W'(1);
      end
    end
  end

  // target lookup: table contents plus same-cycle update bypass
  always_comb begin
    tbl_hit = 1'b0;
    tbl_mac = '0;
    for (int i = 0; i < CACHE_ENTRIES; i++) begin
      if (cv_q[i] && (cip_q[i] == target_q)) begin
        tbl_hit = 1'b1;
        tbl_mac = cmac_q[i];
      end
    end
    byp_hit = upd_ok && (cache_update_ip == target_q);
    hit     = byp_hit || tbl_hit;
    hit_mac = byp_hit ? cache_update_mac : tbl_mac;
  end

  // resolver FSM next-state and registered outputs
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_mac_d   = rsp_mac_q;
    qv_d        = qv_q;
    qip_d       = qip_q;
    target_d    = target_q;
    att_d       = att_q;
    tmr_d       = tmr_q;
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (arp_request_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (is_bcast) begin
            state_d     = S_RESPOND;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_mac_d   = '1;
          end else begin
            target_d = off_net ? gateway_ip : arp_request_ip;
            state_d  = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          state_d     = S_RESPOND;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_mac_d   = hit_mac;
        end else begin
          state_d = S_QUERY;
          att_d   = ATT_LOAD;
          qv_d    = 1'b1;
          qip_d   = target_q;
        end
      end
      S_QUERY: begin
        // matching updates land in the table; WAIT picks them up
        if (query_ready) begin
          qv_d    = 1'b0;
          att_d   = att_q - ATT_W'(1);
          tmr_d   = TMR_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (hit) begin
          state_d     = S_RESPOND;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_mac_d   = hit_mac;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
          if (tmr_q <= TMR_W'(1)) begin
            if (att_q != '0) begin
              state_d = S_QUERY;
              qv_d    = 1'b1;
              qip_d   = target_q;
            end else begin
              state_d     = S_RESPOND;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_mac_d   = '0;
            end
          end
        end
      end
      S_RESPOND: begin
        if (arp_response_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_mac_d   = '0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // state, output and cache registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_mac_q   <= '0;
      qv_q        <= 1'b0;
      qip_q       <= '0;
      busy_q      <= 1'b0;
      target_q    <= '0;
      att_q       <= '0;
      tmr_q       <= '0;
      cv_q        <= '0;
      cip_q       <= '0;
      cmac_q      <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_mac_q   <= rsp_mac_d;
      qv_q        <= qv_d;
      qip_q       <= qip_d;
      busy_q      <= busy_d;
      target_q    <= target_d;
      att_q       <= att_d;
      tmr_q       <= tmr_d;
      cv_q        <= cv_d;
      cip_q       <= cip_d;
      cmac_q      <= cmac_d;
      ptr_q       <= ptr_d;
    end
  end

endmodule

// File: tb/tb_arp_resolver.sv
// Randomized bench for arp_resolver against a behavioural resolver model.
module tb_arp_resolver;
  localparam int NE = 4;
  localparam int RC = 3;
  localparam int RI = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arp_request_valid;
  logic        arp_request_ready;
  logic [31:0] arp_request_ip;
  logic        arp_response_valid;
  logic        arp_response_ready;
  logic        arp_response_error;
  logic [47:0] arp_response_mac;
  logic        cache_update_valid;
  logic [31:0] cache_update_ip;
  logic [47:0] cache_update_mac;
  logic        cache_clear;
  logic        query_valid;
  logic        query_ready;
  logic [31:0] query_ip;
  logic [31:0] local_ip;
  logic [31:0] gateway_ip;
  logic [31:0] subnet_mask;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // model cache: entries replaced in strict arrival order
  logic [31:0] m_ip[NE];
  logic [47:0] m_mac[NE];
  bit          m_v[NE];
  int          m_ptr;

  arp_resolver #(.CACHE_ENTRIES(NE), .RETRY_COUNT(RC), .RETRY_INTERVAL(RI)) dut (
    .clk(clk), .rst_n(rst_n),
    .arp_request_valid(arp_request_valid), .arp_request_ready(arp_request_ready),
    .arp_request_ip(arp_request_ip),
    .arp_response_valid(arp_response_valid), .arp_response_ready(arp_response_ready),
    .arp_response_error(arp_response_error), .arp_response_mac(arp_response_mac),
    .cache_update_valid(cache_update_valid), .cache_update_ip(cache_update_ip),
    .cache_update_mac(cache_update_mac), .cache_clear(cache_clear),
    .query_valid(query_valid), .query_ready(query_ready), .query_ip(query_ip),
    .local_ip(local_ip), .gateway_ip(gateway_ip), .subnet_mask(subnet_mask),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < NE; i++) m_v[i] = 0;
    m_ptr = 0;
  endfunction

  function automatic void m_update(input logic [31:0] ip, input logic [47:0] mac);
    if (ip == 0) return;
    for (int i = 0; i < NE; i++)
      if (m_v[i] && m_ip[i] == ip) begin m_mac[i] = mac; return; end
    m_ip[m_ptr] = ip; m_mac[m_ptr] = mac; m_v[m_ptr] = 1;
    m_ptr = (m_ptr + 1) % NE;
  endfunction

  function automatic bit m_lookup(input logic [31:0] ip, output logic [47:0] mac);
    mac = '0;
    for (int i = 0; i < NE; i++)
      if (m_v[i] && m_ip[i] == ip) begin mac = m_mac[i]; return 1; end
    return 0;
  endfunction

  function automatic logic [31:0] pool();
    return 32'hC0A80100 + 32'($urandom_range(1, 12));
  endfunction

  function automatic logic [47:0] rmac();
    return {16'h0200, 32'($urandom)};
  endfunction

  task automatic do_upd(input logic [31:0] ip, input logic [47:0] mac);
    cache_update_valid = 1; cache_update_ip = ip; cache_update_mac = mac;
    m_update(ip, mac);
    @(negedge clk);
    cache_update_valid = 0;
  endtask

  task automatic do_clear(input bit with_upd, input logic [31:0] ip, input logic [47:0] mac);
    cache_clear = 1;
    cache_update_valid = with_upd; cache_update_ip = ip; cache_update_mac = mac;
    m_clear();
    @(negedge clk);
    cache_clear = 0; cache_update_valid = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, 64'(arp_request_ready), 64'(1'b0));
    chk({tag, "_rv"}, 64'(arp_response_valid), 64'(1'b0));
    chk({tag, "_rerr"}, 64'(arp_response_error), 64'(1'b0));
    chk({tag, "_rmac"}, 64'(arp_response_mac), 64'(0));
    chk({tag, "_qv"}, 64'(query_valid), 64'(1'b0));
    chk({tag, "_qip"}, 64'(query_ip), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
  endtask

  // One full request: expectation from the model, then drive handshakes
  // cycle by cycle. An optional fill is driven fill_k cycles after the
  // first query is accepted.
  task automatic run_req(input logic [31:0] ip, input int fill_k, input bit fill_tgt,
                         input logic [31:0] fill_alt, input logic [47:0] fill_mac,
                         input int qhold, input int rhold);
    logic bc; logic [31:0] tgt, fip; logic [47:0] emac; logic eerr;
    int elat, eq, cyc, qn, qlow, last_acc, hold, k;
    bit seen, done, acc1;
    bc  = (ip == 32'hFFFFFFFF) || ((ip | subnet_mask) == 32'hFFFFFFFF);
    tgt = (((ip ^ local_ip) & subnet_mask) != 0) ? gateway_ip : ip;
    fip = fill_tgt ? tgt : fill_alt;
    if (bc) begin emac = 48'hFFFFFFFFFFFF; eerr = 0; elat = 1; eq = 0; end
    else if (m_lookup(tgt, emac)) begin eerr = 0; elat = 2; eq = 0; end
    else if (fill_k > 0 && fip == tgt) begin emac = fill_mac; eerr = 0; elat = 0; eq = 1; end
    else begin emac = '0; eerr = 1; elat = 0; eq = RC; end

    k = 0;
    while (!arp_request_ready && k < 50) begin @(negedge clk); k++; end
    chk("req_rdy", 64'(arp_request_ready), 64'(1'b1));
    arp_request_valid = 1; arp_request_ip = ip;
    @(negedge clk);
    arp_request_valid = 0;
    chk("rdy_low", 64'(arp_request_ready), 64'(1'b0));

    cyc = 1; seen = 0; done = 0; qn = 0; qlow = 0; acc1 = 0; last_acc = -1000; hold = 0; k = 0;
    while (!done && cyc < 2000) begin
      cache_update_valid = 0;
      if (acc1 && fill_k > 0) begin
        k++;
        if (k == fill_k) begin
          cache_update_valid = 1; cache_update_ip = fip; cache_update_mac = fill_mac;
          m_update(fip, fill_mac);
        end
      end
      query_ready = 0;
      if (query_valid) begin
        chk("q_ip", 64'(query_ip), 64'(tgt));
        if (qlow >= qhold) begin
          query_ready = 1; qn++;
          if (qn > 1) chk("q_space", 64'((cyc - last_acc) >= RI), 64'(1'b1));
          last_acc = cyc; qlow = 0;
          if (!acc1) begin acc1 = 1; k = 0; end
        end else qlow++;
      end
      if (arp_response_valid) begin
        if (!seen) begin
          seen = 1;
          if (elat != 0) chk("rsp_lat", 64'(cyc), 64'(elat));
          chk("rsp_busy", 64'(busy), 64'(1'b1));
        end
        chk("rsp_mac", 64'(arp_response_mac), 64'(emac));
        chk("rsp_err", 64'(arp_response_error), 64'(eerr));
        if (hold >= rhold) begin arp_response_ready = 1; done = 1; end
        else hold++;
      end
      @(negedge clk);
      cyc++;
    end
    arp_response_ready = 0; query_ready = 0; cache_update_valid = 0;
    if (!done) chk("rsp_timeout", 64'(1'b0), 64'(1'b1));
    chk("rsp_drop", 64'(arp_response_valid), 64'(1'b0));
    chk("idle_busy", 64'(busy), 64'(1'b0));
    chk("idle_rdy", 64'(arp_request_ready), 64'(1'b1));
    chk("q_cnt", 64'(qn), 64'(eq));
  endtask

  // Start a request that must miss, reset it during WAIT.
  task automatic rst_in_wait(input logic [31:0] ip);
    int k;
    k = 0;
    while (!arp_request_ready && k < 50) begin @(negedge clk); k++; end
    arp_request_valid = 1; arp_request_ip = ip;
    @(negedge clk);
    arp_request_valid = 0;
    k = 0;
    while (!query_valid && k < 20) begin @(negedge clk); k++; end
    chk("rw_qv", 64'(query_valid), 64'(1'b1));
    query_ready = 1;
    @(negedge clk);
    query_ready = 0;
    repeat (5) @(negedge clk);
    chk("rw_busy", 64'(busy), 64'(1'b1));
    chk("rw_qdone", 64'(query_valid), 64'(1'b0));
    rst_n = 0;
    #1;
    chk_all_zero("rw_rst");
    m_clear();
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rw_rdy0", 64'(arp_request_ready), 64'(1'b0));
    @(negedge clk);
    chk("rw_rdy1", 64'(arp_request_ready), 64'(1'b1));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, r, fk;
    logic [31:0] ip;
    rst_n = 0;
    arp_request_valid = 0; arp_request_ip = 0; arp_response_ready = 0;
    cache_update_valid = 0; cache_update_ip = 0; cache_update_mac = 0; cache_clear = 0;
    query_ready = 0;
    local_ip = 32'hC0A80180; gateway_ip = 32'hC0A80101; subnet_mask = 32'hFFFFFF00;
    m_clear();
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1;
    #1;
    chk("rst_rdy0", 64'(arp_request_ready), 64'(1'b0));
    @(negedge clk);
    chk("rst_rdy1", 64'(arp_request_ready), 64'(1'b1));

    // hit, gateway, broadcast
    do_upd(32'hC0A8010A, 48'h020000000010);
    run_req(32'hC0A8010A, 0, 0, 0, 0, 0, 0);
    do_upd(32'hC0A80101, 48'h020000000001);
    run_req(32'h08080808, 0, 0, 0, 0, 0, 0);
    run_req(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    run_req(32'hC0A801FF, 0, 0, 0, 0, 0, 0);
    // miss then fill, query backpressure
    run_req(32'hC0A80120, 40, 1, 0, 48'h0200000000AA, 3, 0);
    // timeout with response backpressure
    run_req(32'hC0A80121, 0, 0, 0, 0, 0, 5);
    // replacement: fifth update evicts the first
    do_clear(0, 0, 0);
    for (int i = 1; i <= 5; i++) do_upd(32'hC0A80140 + 32'(i), {40'h0200000000, 8'(i)});
    run_req(32'hC0A80141, 0, 0, 0, 0, 1, 0);
    run_req(32'hC0A80145, 0, 0, 0, 0, 0, 0);
    // clear wins over a simultaneous update
    do_clear(1, 32'hC0A80150, 48'h020000000050);
    run_req(32'hC0A80150, 0, 0, 0, 0, 0, 1);
    // reset during WAIT
    rst_in_wait(32'hC0A80133);

    // randomized mix
    for (int it = 0; it < 30; it++) begin
      a = $urandom_range(0, 9);
      if (a < 4) do_upd(pool(), rmac());
      else if (a == 4) do_clear(1'($urandom_range(0, 1)), pool(), rmac());
      else begin
        r = $urandom_range(0, 9);
        if (r == 0) ip = 32'hFFFFFFFF;
        else if (r == 1) ip = 32'hC0A801FF;
        else if (r < 4) ip = {8'h0A, 24'($urandom)};
        else ip = pool();
        fk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
        run_req(ip, fk, 1'($urandom_range(0, 1)), pool(), rmac(),
                $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
